// File: rtl/usb_data_buffer.sv
// usb_data_buffer
//   Shared 64-byte circular byte buffer between the AHB-Lite register side and
//   the USB packet side. Either side may push or pop; the buffer is a single
//   FIFO with first-word fall-through data outputs.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   clear                    : flush pointers/occupancy (memory untouched)
//   store_tx_data, tx_data   : AHB write strobe/byte (wins over RX on conflict)
//   get_rx_data, rx_data     : AHB pop strobe / head byte
//   store_rx_packet_data,
//   rx_packet_data           : USB RX write strobe/byte
//   get_tx_packet_data,
//   tx_packet_data           : USB TX pop strobe / head byte
//   buffer_occupancy         : registered count of valid bytes (0..DEPTH)
//   overflow / underflow     : registered one-cycle pulses for dropped writes /
//                              rejected reads
module usb_data_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              store_tx_data,
  input  logic [7:0]        tx_data,
  input  logic              get_rx_data,
  output logic [7:0]        rx_data,
  input  logic              store_rx_packet_data,
  input  logic [7:0]        rx_packet_data,
  input  logic              get_tx_packet_data,
  output logic [7:0]        tx_packet_data,
  output logic [ADDR_W:0]   buffer_occupancy,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [7:0]      mem_q [DEPTH];
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic [ADDR_W:0] occ_q, occ_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            empty, full;
  logic            wr, rd, wr_ok, rd_ok, mem_we;
  logic [7:0]      wr_byte;
  logic [7:0]      head;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                 (wptr_q[ADDR_W] != rptr_q[ADDR_W]);

  assign wr      = store_tx_data | store_rx_packet_data;
  assign rd      = get_rx_data | get_tx_packet_data;
  assign wr_byte = store_tx_data ? tx_data : rx_packet_data;

  // When full, a same-cycle pop frees the slot the write lands in; the head is
  // read combinationally before the edge, so overwriting it is safe.
  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd_ok);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    mem_we = 1'b0;
    if (clear) begin
      // Flush discards every same-cycle operation silently.
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
    end else begin
      mem_we = wr_ok;
      if (wr_ok) wptr_d = wptr_q + ONE;
      if (rd_ok) rptr_d = rptr_q + ONE;
      if (wr_ok && !rd_ok)      occ_d = occ_q + ONE;
      else if (rd_ok && !wr_ok) occ_d = occ_q - ONE;
      // Dual-strobe write always drops the RX byte, even if the TX byte fits.
      ovf_d = (wr && !wr_ok) || (store_tx_data && store_rx_packet_data);
      unf_d = rd && empty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Storage has no reset; only live entries are ever presented.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[wptr_q[ADDR_W-1:0]] <= wr_byte;
  end

  assign head             = empty ? 8'h00 : mem_q[rptr_q[ADDR_W-1:0]];
  assign rx_data          = head;
  assign tx_packet_data   = head;
  assign buffer_occupancy = occ_q;
  assign overflow         = ovf_q;
  assign underflow        = unf_q;

endmodule

// File: doc/usb_data_buffer.md
# usb_data_buffer

Shared 64-byte circular data buffer for the USB endpoint. It sits directly downstream of `value_registers`. The AHB-Lite side writes bytes in with `store_tx_data`/`tx_data`, drains them with `get_rx_data`/`rx_data`, and flushes the buffer with `clear`. The USB side does the same through the RX and TX packet ports. `buffer_occupancy` feeds back to `value_registers` for status and TX-control decisions.

## Interface
- `DEPTH`, 64: buffer entries in bytes; must be a power of two.
- `ADDR_W`, 6: log2(`DEPTH`); pointer width without the wrap bit.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `clear` in 1: synchronous flush request from `value_registers`.
- `store_tx_data` in 1: AHB-side write strobe, one byte per cycle.
- `tx_data` in 8: AHB-side write byte.
- `get_rx_data` in 1: AHB-side read (pop) strobe.
- `rx_data` out 8: head byte presented to the AHB side.
- `store_rx_packet_data` in 1: USB RX write strobe.
- `rx_packet_data` in 8: USB RX write byte.
- `get_tx_packet_data` in 1: USB TX read (pop) strobe.
- `tx_packet_data` out 8: head byte presented to USB TX.
- `buffer_occupancy` out 7: number of valid bytes, 0..64.
- `overflow` out 1: one-cycle pulse when a write was dropped.
- `underflow` out 1: one-cycle pulse when a read was rejected.

## Operation
- Storage is a `DEPTH` x 8 array with a write pointer and a read pointer, each `ADDR_W`+1 bits (MSB is the wrap bit).
  - Empty: pointers equal.
  - Full: low bits equal and wrap bits differ.
- Write request `wr = store_tx_data | store_rx_packet_data`.
  - If both strobes are high, `tx_data` is stored, the RX byte is dropped and `overflow` pulses.
- Read request `rd = get_rx_data | get_tx_packet_data`.
  - If both strobes are high, exactly one byte is popped.
- Accepted write: `mem[wptr]` <= byte, `wptr` += 1.
- Accepted read: `rptr` += 1.
- Pointers wrap modulo 2*`DEPTH` through natural overflow of the `ADDR_W`+1 bit counters.
- Full, write without read: write dropped, pointers unchanged, `overflow` = 1 next cycle.
- Empty, read: read rejected, `underflow` = 1 next cycle.
- Empty, simultaneous write and read: the write is accepted, the read is rejected and `underflow` pulses. There is no bypass.
- Full, simultaneous write and read: both are accepted and occupancy stays at 64.
- Occupancy updates as follows:
  - +1 on write-only.
  - −1 on read-only.
  - Unchanged on write+read or when the operation is rejected.
  - Kept in its own 7-bit register; must always equal `wptr − rptr`.
- Data outputs are first-word fall-through: `rx_data` = `tx_packet_data` = `mem[rptr[ADDR_W-1:0]]` when not empty, otherwise 8'h00.
- `clear` has priority over every same-cycle read and write.
  - Pointers and occupancy are set to 0.
  - `overflow`/`underflow` are not raised for the discarded operations.
  - Memory contents are left untouched.
- `rst` has priority over `clear`.

## Timing
- Reset values, present the cycle after `rst` is sampled high:
  - `wptr` = `rptr` = 0.
  - `buffer_occupancy` = 0, `overflow` = 0, `underflow` = 0.
  - `rx_data` = `tx_packet_data` = 8'h00.
- Memory is not reset.
- Write latency: a byte strobed at edge N is visible on the data outputs (if it is the head) and counted in `buffer_occupancy` after edge N.
- Read latency: the pop at edge N advances the data outputs to the next entry, and `buffer_occupancy` decrements, after edge N.
- Throughput: one write and one read per cycle, sustained indefinitely, with no stall outputs.
- The data outputs are combinational from the registered read pointer and the array. Every other output is registered.
- `overflow`/`underflow` are high for exactly one cycle per offending cycle. Back-to-back offending cycles give back-to-back pulses.
- `rst` or `clear` asserted mid-burst: the next cycle shows an empty buffer, and the following write lands at index 0.

## Test plan
- Reset: hold `rst` 2 cycles -> occupancy 0, both data outputs 8'h00, no flag pulses.
- Ordering: AHB writes 0x11, 0x22, 0x33, 0x44 -> occupancy 4 and `tx_packet_data` = 0x11; four USB TX pops return 0x11..0x44 in order, then occupancy 0 and output 8'h00.
- Full/overflow: 64 RX writes of 0x00..0x3F, then one more write of 0xAA -> occupancy stays 64 and `overflow` pulses once; draining 64 pops returns 0x00..0x3F with no 0xAA.
- Simultaneous operations:
  - At occupancy 10, one cycle of write 0x5A plus read -> occupancy 10 and the head advances.
  - Both write strobes high -> `tx_data` stored and `overflow` pulses.
- Wrap-around: write/read 60 bytes, then write 8 bytes 0xC0..0xC7 (spanning indices 60→3) -> they read back in order and occupancy returns to 0.
- Empty/clear:
  - Pop at empty -> `underflow` pulse, occupancy 0.
  - At occupancy 20, `clear` with a same-cycle write -> occupancy 0 and no flags.
  - The next write of 0x77 -> `rx_data` = 0x77.
